stepdir_decoder: RTL and testbench



---
 rtl/stepdir_decoder.sv | 143 ++++++++++++++
 tb/tb_stepdir_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepdir_decoder.sv
// Decodes external STEP/DIR pins into a signed 32-bit position, a step period
// and a direction-setup error flag. Both pins are synchronised and glitch filtered.
module stepdir_decoder #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned DIR_SETUP  = 21,
  parameter int unsigned PERIOD_MAX = 3000000,
  parameter bit          INVERT_DIR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        dir,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] position,
  output logic [31:0] period,
  output logic        dir_error,
  output logic        step_pulse
);

  localparam int CW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int AW = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);

  // Bit 0 carries step, bit 1 carries dir through synchroniser and filter.
  logic [1:0] pin_s1, pin_s2, pin_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
    end else begin
      pin_s1 <= {dir, step};
      pin_s2 <= pin_s1;
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign pin_f = pin_s2;
    end else begin : g_filter
      logic [CW-1:0] cnt [2];
      logic [1:0]    filt_q;

      // NOTE: the run counters are a pair of small flop banks, not a memory,
      // so they are reset along with the rest of the filter state.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          filt_q <= '0;
          for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (pin_s2[i] != filt_q[i]) begin
              if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                filt_q[i] <= ~filt_q[i];
                cnt[i]    <= '0;
              end else begin
                cnt[i] <= cnt[i] + CW'(1);
              end
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end

      assign pin_f = filt_q;
    end
  endgenerate

  logic          step_f, dir_f;
  logic          step_f_d, dir_f_d;
  logic [1:0]    sync_valid;
  logic          armed;
  logic [AW-1:0] dir_age;
  logic [31:0]   pcnt;
  logic          first;
  logic [31:0]   pos_q;
  logic          edge_det, dir_chg, setup_viol, count_up, pcnt_sat;

  assign step_f     = pin_f[0];
  assign dir_f      = pin_f[1];
  assign edge_det   = step_f & ~step_f_d & armed;
  assign dir_chg    = dir_f ^ dir_f_d;
  assign setup_viol = dir_chg | (dir_age < AW'(DIR_SETUP));
  assign count_up   = dir_f ^ INVERT_DIR;
  assign pcnt_sat   = (pcnt == 32'(PERIOD_MAX));
  assign position   = pos_q;

  // Arming waits until the synchroniser holds a real pin sample, so a step
  // held high across reset release is never mistaken for a fresh low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_f_d   <= 1'b0;
      dir_f_d    <= 1'b0;
      sync_valid <= '0;
      armed      <= 1'b0;
      dir_age    <= '0;
    end else begin
      step_f_d   <= step_f;
      dir_f_d    <= dir_f;
      sync_valid <= {sync_valid[0], 1'b1};
      if (sync_valid[1] && !pin_s2[0] && !step_f) armed <= 1'b1;
      if (dir_chg)                             dir_age <= '0;
      else if (dir_age != AW'(DIR_SETUP))      dir_age <= dir_age + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      period     <= '0;
      dir_error  <= 1'b0;
      step_pulse <= 1'b0;
      pcnt       <= '0;
      first      <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (!pcnt_sat) pcnt <= pcnt + 32'd1;

      if (clear) begin
        pos_q     <= '0;
        period    <= '0;
        dir_error <= 1'b0;
        pcnt      <= '0;
        first     <= 1'b0;
      end else if (!enable) begin
        period <= '0;
        first  <= 1'b0;
      end else if (edge_det) begin
        pos_q      <= count_up ? pos_q + 32'd1 : pos_q - 32'd1;
        step_pulse <= 1'b1;
        if (setup_viol) dir_error <= 1'b1;
        period     <= (first && !pcnt_sat) ? pcnt + 32'd1 : 32'd0;
        pcnt       <= '0;
        first      <= 1'b1;
      end else if (pcnt_sat) begin
        period <= '0;
        first  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stepdir_decoder.sv
// Directed bench for stepdir_decoder: a timeline model of the pin rules checked
// every cycle against two instances (normal and inverted direction).
module tb_stepdir_decoder;

  localparam int FL   = 3;
  localparam int DS   = 21;
  localparam int PMAX = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0, dir = 1'b0, enable = 1'b0, clear = 1'b0;
  logic [31:0] position, period, position_inv, period_inv;
  logic dir_error, step_pulse, dir_error_inv, step_pulse_inv;

  always #5 clk = ~clk;

  stepdir_decoder #(.FILTER_LEN(FL), .DIR_SETUP(DS), .PERIOD_MAX(PMAX), .INVERT_DIR(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .step(step), .dir(dir), .enable(enable), .clear(clear),
    .position(position), .period(period), .dir_error(dir_error), .step_pulse(step_pulse));

  stepdir_decoder #(.FILTER_LEN(FL), .DIR_SETUP(DS), .PERIOD_MAX(PMAX), .INVERT_DIR(1'b1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .step(step), .dir(dir), .enable(enable), .clear(clear),
    .position(position_inv), .period(period_inv), .dir_error(dir_error_inv),
    .step_pulse(step_pulse_inv));

  int n_vec = 0;
  int n_err = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // Pin samples: hist[0] is the latest clock sample, hist[n] is n samples older.
  logic [FL+1:0] m_shist, m_dhist;
  logic          m_fs, m_fs_prev, m_fd, m_armed, m_have_prev;
  int            m_k, m_last_dchg, m_last_pres;
  logic [31:0]   e_pos, e_pos_inv, e_period;
  logic          e_derr, e_pulse;
  logic          preset_req = 1'b0;
  logic [31:0]   preset_pos = '0, preset_pos_inv = '0;
  logic          skip_cmp = 1'b0;

  // Filtered level moves once the last FL synchronised samples all disagree with it.
  function automatic logic window_differs(input logic [FL+1:0] h, input logic cur);
    for (int i = 1; i <= FL; i++) if (h[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int   gap;
    logic edge_now;
    logic nf_s, nf_d;
    if (!rst_n) begin
      m_shist = '0; m_dhist = '0;
      m_fs = 0; m_fs_prev = 0; m_fd = 0; m_armed = 0; m_have_prev = 0;
      m_k = 0; m_last_dchg = -1; m_last_pres = 0;
      e_pos = 0; e_pos_inv = 0; e_period = 0; e_derr = 0; e_pulse = 0;
    end else begin
      m_k++;
      edge_now = m_fs && !m_fs_prev && m_armed;
      gap      = m_k - m_last_pres;
      e_pulse  = 1'b0;
      if (clear) begin
        e_pos = 0; e_pos_inv = 0; e_period = 0; e_derr = 0;
        m_last_pres = m_k; m_have_prev = 0;
      end else if (!enable) begin
        e_period = 0; m_have_prev = 0;
      end else if (edge_now) begin
        e_pos     = m_fd ? e_pos + 1 : e_pos - 1;
        e_pos_inv = m_fd ? e_pos_inv - 1 : e_pos_inv + 1;
        e_pulse   = 1'b1;
        if (m_k - m_last_dchg < DS + 2) e_derr = 1'b1;
        e_period    = (m_have_prev && gap <= PMAX) ? gap : 0;
        m_last_pres = m_k;
        m_have_prev = 1'b1;
      end else if (gap - 1 >= PMAX) begin
        e_period = 0; m_have_prev = 0;
      end
      if (preset_req) begin
        e_pos = preset_pos; e_pos_inv = preset_pos_inv;
      end
      if (m_k >= 3 && !m_shist[1] && !m_fs) m_armed = 1'b1;
      nf_s = window_differs(m_shist, m_fs) ? !m_fs : m_fs;
      nf_d = window_differs(m_dhist, m_fd) ? !m_fd : m_fd;
      if (nf_d != m_fd) m_last_dchg = m_k;
      m_fs_prev = m_fs;
      m_fs      = nf_s;
      m_fd      = nf_d;
      m_shist   = {m_shist[FL:0], step};
      m_dhist   = {m_dhist[FL:0], dir};
    end
  end

  always @(negedge clk) begin
    if (step_pulse) n_pulses++;
    if (!skip_cmp) begin
      check("position",       position,       e_pos);
      check("position_inv",   position_inv,   e_pos_inv);
      check("period",         period,         e_period);
      check("period_inv",     period_inv,     e_period);
      check("dir_error",      {31'd0, dir_error},      {31'd0, e_derr});
      check("dir_error_inv",  {31'd0, dir_error_inv},  {31'd0, e_derr});
      check("step_pulse",     {31'd0, step_pulse},     {31'd0, e_pulse});
      check("step_pulse_inv", {31'd0, step_pulse_inv}, {31'd0, e_pulse});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    step = 1'b1; tick(hi);
    step = 1'b0; tick(lo);
  endtask

  initial begin : stim
    int p0;
    dir = 1'b1; enable = 1'b1;
    tick(3);
    check("reset_position", position, 32'd0);
    check("reset_period",   period,   32'd0);
    check("reset_pulse",    {31'd0, step_pulse}, 32'd0);
    rst_n = 1'b1;
    tick(40);

    // Five clean up-steps; first one also pins the pin-to-strobe latency.
    p0 = n_pulses;
    step = 1'b1; tick(5);
    check("latency_early", {31'd0, step_pulse}, 32'd0);
    tick(1);
    check("latency_6", {31'd0, step_pulse}, 32'd1);
    tick(4); step = 1'b0; tick(10);
    repeat (4) pulse(10, 10);
    tick(10);
    check("up5_position",  position,     32'd5);
    check("up5_inv",       position_inv, 32'hFFFF_FFFB);
    check("up5_pulses",    n_pulses - p0, 32'd5);
    check("up5_dir_error", {31'd0, dir_error}, 32'd0);

    // Down-steps after a long dir setup.
    dir = 1'b0; tick(30);
    repeat (3) pulse(10, 10);
    check("down3_position", position,     32'd2);
    check("down3_inv",      position_inv, 32'hFFFF_FFFE);

    // Short glitches are rejected.
    p0 = n_pulses;
    repeat (3) begin step = 1'b1; tick(2); step = 1'b0; tick(10); end
    step = 1'b1; tick(1); step = 1'b0; tick(10);
    check("glitch_position", position, 32'd2);
    check("glitch_pulses",   n_pulses - p0, 32'd0);

    // Dir changed too close to a step: counted with new dir, error latched.
    dir = 1'b1; tick(10);
    pulse(10, 10);
    check("setup_position",  position, 32'd3);
    check("setup_dir_error", {31'd0, dir_error}, 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_position",  position, 32'd0);
    check("clear_dir_error", {31'd0, dir_error}, 32'd0);
    tick(30);

    // Period: first edge 0, then the 300-cycle spacing; idle past PERIOD_MAX.
    pulse(10, 290);
    check("period_first", period, 32'd0);
    check("period_no_err", {31'd0, dir_error}, 32'd0);
    repeat (3) pulse(10, 290);
    check("period_300", period, 32'd300);
    tick(1100);
    check("period_idle", period, 32'd0);
    pulse(10, 290);
    check("period_after_idle", period, 32'd0);
    pulse(10, 290);
    check("period_resume", period, 32'd300);

    // Wrap in both directions via preset of the position registers.
    skip_cmp = 1'b1;
    force u_dut.pos_q     = 32'h7FFF_FFFF;
    force u_dut_inv.pos_q = 32'h8000_0000;
    preset_pos = 32'h7FFF_FFFF; preset_pos_inv = 32'h8000_0000; preset_req = 1'b1;
    tick(1);
    preset_req = 1'b0;
    release u_dut.pos_q;
    release u_dut_inv.pos_q;
    tick(1);
    skip_cmp = 1'b0;
    pulse(10, 10);
    check("wrap_up",   position,     32'h8000_0000);
    check("wrap_down", position_inv, 32'h7FFF_FFFF);

    // Reset with step held high: no count until step drops and rises again.
    step = 1'b1; tick(20);
    rst_n = 1'b0; #1;
    check("midreset_position", position, 32'd0);
    tick(3);
    rst_n = 1'b1;
    p0 = n_pulses;
    tick(30);
    check("held_position", position, 32'd0);
    check("held_pulses",   n_pulses - p0, 32'd0);
    step = 1'b0; tick(20);
    pulse(10, 10);
    pulse(10, 10);
    check("rearm_position",  position, 32'd2);
    check("rearm_period",    period,   32'd20);
    check("rearm_dir_error", {31'd0, dir_error}, 32'd0);

    // Disabled counting.
    enable = 1'b0;
    p0 = n_pulses;
    repeat (4) pulse(10, 10);
    check("disable_position", position, 32'd2);
    check("disable_period",   period,   32'd0);
    check("disable_pulses",   n_pulses - p0, 32'd0);
    enable = 1'b1; tick(5);

    // Clear on the exact edge cycle drops the edge.
    p0 = n_pulses;
    step = 1'b1; tick(5);
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(5); step = 1'b0; tick(10);
    check("clear_edge_position", position, 32'd0);
    check("clear_edge_pulses",   n_pulses - p0, 32'd0);
    pulse(10, 10);
    check("after_clear_position", position, 32'd1);
    check("after_clear_period",   period,   32'd0);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
